// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake renderer: board geometry and
// the mapping from a packed {x, y} position to a bitmap index.
package snake_pkg;

   localparam int MATRIX_W = 16;
   localparam int MATRIX_H = 8;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
   } pos_t;

   // Row-major index into the 128-bit body bitmap; y[3] is not part of the index
   function automatic logic [6:0] posToIdx(input pos_t p);
      return {p.y[2:0], p.x};
   endfunction

endpackage

// File: rtl/body_fifo.sv
// Show-ahead FIFO holding the snake body, head pushed in, tail popped out.
// The tail entry is on dout combinationally so it can be cleared on the
// same edge it is popped. The caller never pops empty or pushes full.
module body_fifo #(
   parameter int DEPTH = 128
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic [7:0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;

   assign dout = mem[rdPtr];

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= din;
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 8'd1;
            2'b01:   count <= count - 8'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/snake_render.sv
// Snake body tracker and LED-matrix scanner. Each step pushes the new head,
// pops the tail once the body reaches its target length, and grows the
// target when the head lands on food. The bitmap is scanned row by row.
module snake_render
   import snake_pkg::*;
#(
   parameter int SCAN_DIV = 1024,
   parameter int DEPTH    = 128,
   parameter int INIT_LEN = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step,
   input  logic [7:0]  head_pos,
   input  logic [7:0]  food_pos,
   input  logic        food_valid,
   output logic        grow,
   output logic [7:0]  length,
   output logic [7:0]  MATRIX_ROW,
   output logic [15:0] MATRIX_COL
);

   localparam int RW = $clog2(MATRIX_H);

   logic [127:0]        bitmap, bitmapNext;
   logic [7:0]          target;
   logic [7:0]          tailRaw;
   pos_t                headP, tailP;
   logic                eat, doPop, doPush;
   logic [31:0]         scanCnt;
   logic                scanWrap;
   logic [RW-1:0]       row, rowNext;
   logic [MATRIX_W-1:0] colNext;

   assign headP = head_pos;
   assign tailP = tailRaw;

   body_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk   (clk),
      .reset (reset),
      .push  (doPush),
      .pop   (doPop),
      .din   (head_pos),
      .dout  (tailRaw),
      .count (length)
   );

   // Step decode: eating suppresses the pop; a full body without a pop drops the push
   always_comb begin
      eat    = step && food_valid && (head_pos == food_pos);
      doPop  = step && !eat && (length == target) && (length != 8'd0);
      doPush = step && !((length == 8'(DEPTH)) && !doPop);
   end

   // Tail clear before head set, so a head landing on the old tail stays lit
   always_comb begin
      bitmapNext = bitmap;
      if (doPop && !tailP.y[3])  bitmapNext[posToIdx(tailP)] = 1'b0;
      if (doPush && !headP.y[3]) bitmapNext[posToIdx(headP)] = 1'b1;
   end

   // Body bitmap, target length and the eat pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bitmap <= '0;
         target <= 8'(INIT_LEN);
         grow   <= 1'b0;
      end else begin
         bitmap <= bitmapNext;
         grow   <= eat;
         if (eat && (target < 8'(DEPTH))) target <= target + 8'd1;
      end
   end

   // Next row and its pixels; computed together so row and columns stay aligned
   always_comb begin
      scanWrap = (scanCnt == 32'(SCAN_DIV - 1));
      rowNext  = scanWrap ? row + 1'b1 : row;
      colNext  = '0;
      for (int i = 0; i < MATRIX_W; i++)
         colNext[i] = bitmap[{rowNext, i[3:0]}] ||
                      (food_valid && (food_pos == {i[3:0], 1'b0, rowNext}));
   end

   // Row scan counter and registered matrix drive
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scanCnt    <= '0;
         row        <= '0;
         MATRIX_ROW <= 8'h01;
         MATRIX_COL <= '0;
      end else begin
         scanCnt    <= scanWrap ? 32'd0 : scanCnt + 32'd1;
         row        <= rowNext;
         MATRIX_ROW <= 8'd1 << rowNext;
         MATRIX_COL <= colNext;
      end
   end

endmodule

// File: tb/tb_snake_render.sv
// Directed bench for snake_render: body push/pop, eating, tail==head,
// food display, row scan timing, depth saturation and mid-run reset.
module tb_snake_render;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        step = 1'b0;
   logic [7:0]  head_pos = '0;
   logic [7:0]  food_pos = '0;
   logic        food_valid = 1'b0;
   logic        grow;
   logic [7:0]  length;
   logic [7:0]  MATRIX_ROW;
   logic [15:0] MATRIX_COL;

   int nCmp = 0;
   int nBad = 0;

   snake_render #(.SCAN_DIV(4), .DEPTH(128), .INIT_LEN(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .step       (step),
      .head_pos   (head_pos),
      .food_pos   (food_pos),
      .food_valid (food_valid),
      .grow       (grow),
      .length     (length),
      .MATRIX_ROW (MATRIX_ROW),
      .MATRIX_COL (MATRIX_COL)
   );

   always #5 clk = ~clk;

   // Reset for two cycles, release on a negedge
   task automatic doReset();
      reset = 1'b0; step = 1'b0; food_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // One-cycle step; returns on the negedge after the capturing edge
   task automatic doStep(input logic [7:0] p);
      step = 1'b1; head_pos = p;
      @(negedge clk);
      step = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; step = 1'b1; head_pos = 8'h00;
      repeat (3) @(negedge clk);
      step = 1'b0;
      reset = 1'b1;
      nCmp++; if (length !== 8'd0) begin nBad++; $display("FAIL rst_len: got %0d want 0", length); end
      nCmp++; if (grow !== 1'b0) begin nBad++; $display("FAIL rst_grow: got %b want 0", grow); end
      nCmp++; if (MATRIX_ROW !== 8'h01) begin nBad++; $display("FAIL rst_row: got %h want 01", MATRIX_ROW); end
      nCmp++; if (MATRIX_COL !== 16'h0000) begin nBad++; $display("FAIL rst_col: got %h want 0000", MATRIX_COL); end
      nCmp++; if (dut.bitmap !== 128'd0) begin nBad++; $display("FAIL rst_bitmap: got %h want 0", dut.bitmap); end
   endtask

   task automatic test_body();
      doReset();
      doStep(8'h00); doStep(8'h10); doStep(8'h20);
      nCmp++; if (length !== 8'd3) begin nBad++; $display("FAIL fill3_len: got %0d want 3", length); end
      nCmp++; if (dut.bitmap[7:0] !== 8'b0000_0111) begin nBad++; $display("FAIL fill3_bm: got %b want 00000111", dut.bitmap[7:0]); end
      doStep(8'h30);
      nCmp++; if (length !== 8'd3) begin nBad++; $display("FAIL pop_len: got %0d want 3", length); end
      nCmp++; if (dut.bitmap[7:0] !== 8'b0000_1110) begin nBad++; $display("FAIL pop_bm: got %b want 00001110", dut.bitmap[7:0]); end
      nCmp++; if (grow !== 1'b0) begin nBad++; $display("FAIL pop_grow: got %b want 0", grow); end
   endtask

   task automatic test_eat();
      food_pos = 8'h40; food_valid = 1'b1;
      doStep(8'h40);
      nCmp++; if (grow !== 1'b1) begin nBad++; $display("FAIL eat_grow: got %b want 1", grow); end
      nCmp++; if (length !== 8'd4) begin nBad++; $display("FAIL eat_len: got %0d want 4", length); end
      nCmp++; if (dut.bitmap[7:0] !== 8'b0001_1110) begin nBad++; $display("FAIL eat_bm: got %b want 00011110", dut.bitmap[7:0]); end
      @(negedge clk);
      nCmp++; if (grow !== 1'b0) begin nBad++; $display("FAIL eat_pulse: got %b want 0", grow); end
      food_valid = 1'b0;
      doStep(8'h50);
      nCmp++; if (length !== 8'd4) begin nBad++; $display("FAIL after_len: got %0d want 4", length); end
      nCmp++; if (dut.bitmap[7:0] !== 8'b0011_1100) begin nBad++; $display("FAIL after_bm: got %b want 00111100", dut.bitmap[7:0]); end
   endtask

   // Body is 20,30,40,50; stepping onto 20 pops and re-lights the same pixel
   task automatic test_tail_is_head();
      doStep(8'h20);
      nCmp++; if (length !== 8'd4) begin nBad++; $display("FAIL tailhead_len: got %0d want 4", length); end
      nCmp++; if (dut.bitmap[7:0] !== 8'b0011_1100) begin nBad++; $display("FAIL tailhead_bm: got %b want 00111100", dut.bitmap[7:0]); end
   endtask

   task automatic test_food_display();
      doReset();
      food_pos = 8'h50; food_valid = 1'b1;
      @(negedge clk);
      nCmp++; if (MATRIX_COL !== 16'h0020) begin nBad++; $display("FAIL food_col: got %h want 0020", MATRIX_COL); end
      food_pos = 8'h58;
      @(negedge clk);
      nCmp++; if (MATRIX_COL !== 16'h0000) begin nBad++; $display("FAIL food_y8: got %h want 0000", MATRIX_COL); end
      food_valid = 1'b0;
   endtask

   task automatic test_scan();
      logic [7:0]  expRow;
      logic [15:0] expCol;
      logic [2:0]  r;
      doReset();
      step = 1'b1; head_pos = 8'h01;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (k == 1) head_pos = 8'h11;
         if (k == 2) step = 1'b0;
         r = 3'((k / 4) % 8);
         expRow = 8'h01 << r;
         expCol = (r == 3'd1) ? 16'h0003 : 16'h0000;
         nCmp++; if (MATRIX_ROW !== expRow) begin nBad++; $display("FAIL scan_row c%0d: got %h want %h", k, MATRIX_ROW, expRow); end
         nCmp++; if (MATRIX_COL !== expCol) begin nBad++; $display("FAIL scan_col c%0d: got %h want %h", k, MATRIX_COL, expCol); end
      end
   endtask

   task automatic test_depth_and_reset();
      doReset();
      food_valid = 1'b1;
      step = 1'b1;
      for (int i = 0; i < 128; i++) begin
         head_pos = 8'(i); food_pos = 8'(i);
         @(negedge clk);
      end
      nCmp++; if (length !== 8'd128) begin nBad++; $display("FAIL full_len: got %0d want 128", length); end
      nCmp++; if (grow !== 1'b1) begin nBad++; $display("FAIL full_grow: got %b want 1", grow); end
      head_pos = 8'h77; food_pos = 8'h77;
      @(negedge clk);
      nCmp++; if (length !== 8'd128) begin nBad++; $display("FAIL sat_len: got %0d want 128", length); end
      nCmp++; if (grow !== 1'b1) begin nBad++; $display("FAIL sat_grow: got %b want 1", grow); end
      #2 reset = 1'b0;
      #1;
      nCmp++; if (length !== 8'd0) begin nBad++; $display("FAIL mid_len: got %0d want 0", length); end
      nCmp++; if (grow !== 1'b0) begin nBad++; $display("FAIL mid_grow: got %b want 0", grow); end
      nCmp++; if (MATRIX_ROW !== 8'h01) begin nBad++; $display("FAIL mid_row: got %h want 01", MATRIX_ROW); end
      nCmp++; if (MATRIX_COL !== 16'h0000) begin nBad++; $display("FAIL mid_col: got %h want 0000", MATRIX_COL); end
      step = 1'b0; food_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      doStep(8'h00); doStep(8'h10); doStep(8'h20); doStep(8'h30);
      nCmp++; if (length !== 8'd3) begin nBad++; $display("FAIL post_len: got %0d want 3", length); end
   endtask

   initial begin
      test_reset();
      test_body();
      test_eat();
      test_tail_is_head();
      test_food_display();
      test_scan();
      test_depth_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
